bank_group_ctrl: RTL and testbench



---
 rtl/bank_group_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_bank_group_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_group_ctrl.sv
// Bank-group controller: per-bank ACT/PRE timing FSMs plus one shared RD/WR burst engine.
// Latency: bank_state, cmd_err and the beat outputs are registered; beat 0 follows an accepted RD/WR by one cycle.
// Backpressure: cmd_ready drops only for RD/WR while a burst is running, except on its last beat.
module bank_group_ctrl #(
  parameter int BAWIDTH       = 2,
  parameter int ADDRWIDTH     = 17,
  parameter int COLWIDTH      = 10,
  parameter int BL            = 8,
  parameter int TRCD          = 4,
  parameter int TRP           = 4,
  localparam int BANKSPERGROUP = 2**BAWIDTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [2:0]                         cmd,
  input  logic [BAWIDTH-1:0]                 cmd_ba,
  input  logic [ADDRWIDTH-1:0]               cmd_addr,
  output logic                               cmd_err,
  output logic [BANKSPERGROUP-1:0][2:0]      bank_state,
  output logic                               mem_en,
  output logic                               mem_we,
  output logic [BAWIDTH-1:0]                 mem_ba,
  output logic [ADDRWIDTH-1:0]               mem_row,
  output logic [COLWIDTH-1:0]                mem_col,
  output logic                               burst_last
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ACTIVATING  = 3'd1,
    S_ACTIVE      = 3'd2,
    S_BURST       = 3'd3,
    S_PRECHARGING = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ACT = 3'd1;
  localparam logic [2:0] OP_RD  = 3'd2;
  localparam logic [2:0] OP_WR  = 3'd3;
  localparam logic [2:0] OP_PRE = 3'd4;

  localparam int TMAX = (TRCD > TRP) ? TRCD : TRP;
  localparam int CNTW = $clog2(TMAX + 1);
  localparam int LBL  = $clog2(BL);
  // Low column bits that wrap within the burst block.
  localparam logic [COLWIDTH-1:0] LO_MASK = COLWIDTH'(BL - 1);

  logic [BANKSPERGROUP-1:0][2:0]           r_state;
  logic [BANKSPERGROUP-1:0][ADDRWIDTH-1:0] r_row;
  logic [BANKSPERGROUP-1:0][CNTW-1:0]      r_cnt;

  logic                 r_mem_en;
  logic                 r_mem_we;
  logic [BAWIDTH-1:0]   r_mem_ba;
  logic [ADDRWIDTH-1:0] r_mem_row;
  logic [COLWIDTH-1:0]  r_mem_col;
  logic                 r_burst_last;
  logic [LBL-1:0]       r_beat;
  logic                 r_err;

  logic                     w_is_rdwr;
  logic                     w_accept;
  logic                     w_illegal;
  logic [2:0]               w_cur;
  logic                     w_go_act;
  logic                     w_go_rdwr;
  logic                     w_go_pre;
  logic [BANKSPERGROUP-1:0] w_bank_sel;
  logic [LBL-1:0]           w_beat_nxt;
  logic [COLWIDTH-1:0]      w_col_nxt;

  assign w_is_rdwr  = (cmd == OP_RD) || (cmd == OP_WR);
  assign cmd_ready  = rst_n && !(w_is_rdwr && r_mem_en && !r_burst_last);
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_cur      = r_state[cmd_ba];
  assign w_bank_sel = BANKSPERGROUP'(1) << cmd_ba;
  assign w_go_act   = w_accept && !w_illegal && (cmd == OP_ACT);
  assign w_go_rdwr  = w_accept && !w_illegal && w_is_rdwr;
  // PRE on an IDLE bank is accepted but only an ACTIVE bank actually precharges.
  assign w_go_pre   = w_accept && !w_illegal && (cmd == OP_PRE) && (w_cur == S_ACTIVE);
  assign w_beat_nxt = r_beat + LBL'(1);
  assign w_col_nxt  = (r_mem_col & ~LO_MASK) | ((r_mem_col + COLWIDTH'(1)) & LO_MASK);

  // Classify the presented command against the target bank's current state.
  always_comb begin
    w_illegal = 1'b0;
    case (cmd)
      OP_NOP:       w_illegal = 1'b0;
      OP_ACT:       w_illegal = (w_cur != S_IDLE);
      OP_RD, OP_WR: w_illegal = !((w_cur == S_ACTIVE) ||
                                  ((w_cur == S_BURST) && r_burst_last && (r_mem_ba == cmd_ba)));
      OP_PRE:       w_illegal = !((w_cur == S_IDLE) || (w_cur == S_ACTIVE));
      default:      w_illegal = 1'b1;
    endcase
  end

  // Per-bank state machines; counters count down so the state flips exactly TRCD/TRP cycles after the command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_row   <= '0;
      r_cnt   <= '0;
    end else begin
      for (int b = 0; b < BANKSPERGROUP; b++) begin
        case (r_state[b])
          S_IDLE: begin
            if (w_go_act && w_bank_sel[b]) begin
              r_row[b] <= cmd_addr;
              if (TRCD == 1) begin
                r_state[b] <= S_ACTIVE;
              end else begin
                r_state[b] <= S_ACTIVATING;
                r_cnt[b]   <= CNTW'(TRCD - 1);
              end
            end
          end
          S_ACTIVATING: begin
            if (r_cnt[b] <= CNTW'(1)) begin
              r_cnt[b]   <= '0;
              r_state[b] <= S_ACTIVE;
            end else begin
              r_cnt[b] <= r_cnt[b] - CNTW'(1);
            end
          end
          S_ACTIVE: begin
            if (w_go_rdwr && w_bank_sel[b]) begin
              r_state[b] <= S_BURST;
            end else if (w_go_pre && w_bank_sel[b]) begin
              if (TRP == 1) begin
                r_state[b] <= S_IDLE;
              end else begin
                r_state[b] <= S_PRECHARGING;
                r_cnt[b]   <= CNTW'(TRP - 1);
              end
            end
          end
          S_BURST: begin
            if (r_burst_last && (r_mem_ba == BAWIDTH'(b)) && !(w_go_rdwr && w_bank_sel[b])) begin
              r_state[b] <= S_ACTIVE;
            end
          end
          S_PRECHARGING: begin
            if (r_cnt[b] <= CNTW'(1)) begin
              r_cnt[b]   <= '0;
              r_state[b] <= S_IDLE;
            end else begin
              r_cnt[b] <= r_cnt[b] - CNTW'(1);
            end
          end
          default: r_state[b] <= S_IDLE;
        endcase
      end
    end
  end

  // Shared burst engine: a new RD/WR overrides the final beat so consecutive bursts stream without a gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_ba     <= '0;
      r_mem_row    <= '0;
      r_mem_col    <= '0;
      r_burst_last <= 1'b0;
      r_beat       <= '0;
      r_err        <= 1'b0;
    end else begin
      r_err <= w_accept && w_illegal;
      if (w_go_rdwr) begin
        r_mem_en     <= 1'b1;
        r_mem_we     <= (cmd == OP_WR);
        r_mem_ba     <= cmd_ba;
        r_mem_row    <= r_row[cmd_ba];
        r_mem_col    <= cmd_addr[COLWIDTH-1:0];
        r_beat       <= '0;
        r_burst_last <= 1'b0;
      end else if (r_mem_en && !r_burst_last) begin
        r_mem_col    <= w_col_nxt;
        r_beat       <= w_beat_nxt;
        r_burst_last <= (w_beat_nxt == LBL'(BL - 1));
      end else begin
        r_mem_en     <= 1'b0;
        r_burst_last <= 1'b0;
      end
    end
  end

  assign bank_state = r_state;
  assign cmd_err    = r_err;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_ba     = r_mem_ba;
  assign mem_row    = r_mem_row;
  assign mem_col    = r_mem_col;
  assign burst_last = r_burst_last;

endmodule

// File: tb/tb_bank_group_ctrl.sv
// Directed bench for bank_group_ctrl: expected beats queued at issue, checked by a beat monitor.
// Latency: inputs change 1ns after the rising edge; outputs checked there or on the falling edge.
// Backpressure: cmd_ready is checked explicitly while a burst holds off a RD/WR.
module tb_bank_group_ctrl;

  localparam int BAW = 2;
  localparam int AW  = 17;
  localparam int CW  = 10;
  localparam int BLT = 8;

  logic               clk;
  logic               rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd;
  logic [BAW-1:0]     cmd_ba;
  logic [AW-1:0]      cmd_addr;
  logic               cmd_err;
  logic [3:0][2:0]    bank_state;
  logic               mem_en;
  logic               mem_we;
  logic [BAW-1:0]     mem_ba;
  logic [AW-1:0]      mem_row;
  logic [CW-1:0]      mem_col;
  logic               burst_last;

  bank_group_ctrl #(
    .BAWIDTH(BAW), .ADDRWIDTH(AW), .COLWIDTH(CW), .BL(BLT), .TRCD(4), .TRP(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr), .cmd_err(cmd_err),
    .bank_state(bank_state), .mem_en(mem_en), .mem_we(mem_we), .mem_ba(mem_ba),
    .mem_row(mem_row), .mem_col(mem_col), .burst_last(burst_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [1:0]    ba;
    logic [16:0]   row;
    logic [9:0]    col;
    logic          last;
  } beat_t;

  beat_t sb_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beat list of one burst in wrap-within-block order.
  task automatic push_burst(input logic we, input logic [1:0] ba, input logic [16:0] row, input logic [9:0] s);
    beat_t b;
    for (int i = 0; i < BLT; i++) begin
      b.we   = we;
      b.ba   = ba;
      b.row  = row;
      b.col  = (s & ~10'(BLT - 1)) | ((s + 10'(i)) & 10'(BLT - 1));
      b.last = (i == BLT - 1);
      sb_q.push_back(b);
    end
  endtask

  // Beat monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL beat_unexpected: got ba=%0h col=%0h, expected no beat at %0t", mem_ba, mem_col, $time);
      end else begin
        beat_t e;
        e = sb_q.pop_front();
        chk("beat", {mem_we, mem_ba, mem_row, mem_col, burst_last}, e);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [2:0] op, input logic [1:0] ba, input logic [16:0] addr);
    cmd_valid = 1'b1;
    cmd       = op;
    cmd_ba    = ba;
    cmd_addr  = addr;
  endtask

  task automatic idle_cmd;
    cmd_valid = 1'b0;
    cmd       = 3'd0;
    cmd_ba    = '0;
    cmd_addr  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a command held valid: nothing may be accepted.
    rst_n = 1'b0;
    present(3'd1, 2'd0, 17'h00005);
    repeat (3) tick;
    #1;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_err", cmd_err, 0);
    chk("rst_mem", {mem_en, mem_we, burst_last, mem_ba, mem_row, mem_col}, 0);
    chk("rst_state", bank_state, 0);
    idle_cmd;
    rst_n = 1'b1;
    tick;
    chk("rst_after", bank_state, 0);

    // ACT bank 1, then an early RD while it is still activating.
    present(3'd1, 2'd1, 17'h1ABCD);
    #1 chk("act1_ready", cmd_ready, 1);
    tick; idle_cmd;                                   // t+1
    chk("act1_t1", bank_state[1], 1);
    tick;                                             // t+2
    chk("act1_t2", bank_state[1], 1);
    present(3'd2, 2'd1, 17'h0);
    tick; idle_cmd;                                   // t+3
    chk("rd_early_err", cmd_err, 1);
    chk("act1_t3", bank_state[1], 1);
    tick;                                             // t+4
    chk("act1_t4", bank_state[1], 2);
    chk("rd_early_err_clr", cmd_err, 0);
    chk("rd_early_noburst", mem_en, 0);

    // Open bank 0 (row 5) and bank 2 (row 0x222).
    present(3'd1, 2'd0, 17'h00005);
    tick;
    present(3'd1, 2'd2, 17'h00222);
    tick; idle_cmd;
    repeat (4) tick;
    chk("b0_active", bank_state[0], 2);
    chk("b2_active", bank_state[2], 2);

    // RD bank 0 col 0x3FD: wrapped column order, single burst.
    present(3'd2, 2'd0, 17'h003FD);
    push_burst(1'b0, 2'd0, 17'h00005, 10'h3FD);
    tick; idle_cmd;
    for (int i = 1; i <= BLT; i++) begin
      chk("rd0_en", mem_en, 1);
      chk("rd0_state", bank_state[0], 3);
      tick;
    end
    chk("rd0_done_en", mem_en, 0);
    chk("rd0_done_state", bank_state[0], 2);

    // WR bank 0 then RD bank 2 held off until the last write beat.
    present(3'd3, 2'd0, 17'h00000);
    push_burst(1'b1, 2'd0, 17'h00005, 10'h000);
    tick;                                             // t+1
    present(3'd2, 2'd2, 17'h00008);
    for (int k = 1; k <= 7; k++) begin
      #1 chk("stall_ready", cmd_ready, 0);
      tick;
    end
    #1 chk("b2b_ready", cmd_ready, 1);                // t+8
    chk("b2b_we_t8", mem_we, 1);
    chk("b2b_last_t8", burst_last, 1);
    push_burst(1'b0, 2'd2, 17'h00222, 10'h008);
    tick; idle_cmd;                                   // t+9
    chk("b2b_we_t9", mem_we, 0);
    chk("b2b_b0_state", bank_state[0], 2);
    chk("b2b_b2_state", bank_state[2], 3);
    for (int i = 9; i <= 16; i++) begin
      chk("b2b_en", mem_en, 1);
      tick;
    end
    chk("b2b_done", mem_en, 0);

    // Precharge bank 2 and follow its timing.
    present(3'd4, 2'd2, 17'h0);
    tick; idle_cmd;
    for (int i = 1; i <= 3; i++) begin
      chk("pre2_state", bank_state[2], 4);
      tick;
    end
    chk("pre2_idle", bank_state[2], 0);

    // During a bank 0 burst: ACT bank 3, PRE idle bank 2, illegal opcode 6.
    present(3'd2, 2'd0, 17'h00010);
    push_burst(1'b0, 2'd0, 17'h00005, 10'h010);
    tick;                                             // t+1
    present(3'd1, 2'd3, 17'h1F00F);
    #1 chk("par_act_ready", cmd_ready, 1);
    tick;                                             // t+2
    present(3'd4, 2'd2, 17'h0);
    #1 chk("par_pre_ready", cmd_ready, 1);
    chk("par_act_err", cmd_err, 0);
    chk("par_b3_actv", bank_state[3], 1);
    tick;                                             // t+3
    present(3'd6, 2'd0, 17'h0);
    #1 chk("par_pre_err", cmd_err, 0);
    chk("par_b2_idle", bank_state[2], 0);
    tick; idle_cmd;                                   // t+4
    chk("op6_err", cmd_err, 1);
    chk("par_b3_t4", bank_state[3], 1);
    tick;                                             // t+5
    chk("op6_err_clr", cmd_err, 0);
    chk("par_b3_active", bank_state[3], 2);
    chk("par_b0_burst", bank_state[0], 3);
    repeat (4) tick;                                  // t+9

    // WR bank 1 checks the row latched by the first ACT.
    present(3'd3, 2'd1, 17'h003F2);
    push_burst(1'b1, 2'd1, 17'h1ABCD, 10'h3F2);
    tick; idle_cmd;
    repeat (BLT) tick;
    chk("wr1_done", mem_en, 0);

    // PRE bank 0 timing.
    present(3'd4, 2'd0, 17'h0);
    tick; idle_cmd;
    for (int i = 1; i <= 3; i++) begin
      chk("pre0_state", bank_state[0], 4);
      tick;
    end
    chk("pre0_idle", bank_state[0], 0);

    // Reset two cycles into a bank 3 burst: only beat 0 may appear.
    present(3'd2, 2'd3, 17'h00020);
    sb_q.push_back(beat_t'{1'b0, 2'd3, 17'h1F00F, 10'h020, 1'b0});
    tick; idle_cmd;                                   // t+1
    chk("abort_en_t1", mem_en, 1);
    tick;                                             // t+2
    rst_n = 1'b0;
    #1;
    chk("abort_en", mem_en, 0);
    chk("abort_state", bank_state, 0);
    chk("abort_ready", cmd_ready, 0);
    repeat (2) tick;
    rst_n = 1'b1;
    repeat (3) tick;
    chk("abort_quiet", mem_en, 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
